// File: rtl/overture_run_ctrl.sv
// overture_run_ctrl: execution sequencer for the Overture 8-bit CPU.
// Gates the CPU run enable for free-run, single-step and run-N commands,
// halts on host request, PC breakpoint or (optionally) a jump-to-self, and
// counts retired instructions (one cpu_run cycle = one instruction).
// Latency: cpu_run responds combinationally to halt_req/bp/reset; state and
// halt_cause/done update on the clock edge after the halt condition.
// Backpressure: cmd_ready is high only while IDLE; a command is taken on
// cmd_valid & cmd_ready.
// Ports: clk/reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_count
// host command; halt_req, bp_en/bp_addr debug controls; cpu_pc observed PC;
// cpu_run, busy, halt_cause, done, instr_count status outputs.
// Optional: define OVERTURE_RUN_CTRL_LOOP_EN to enable self-loop detection
// (halt_cause 3); without it halt_cause never reads 3.
module overture_run_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [7:0]        bp_addr,
  input  logic [7:0]        cpu_pc,
  output logic              cpu_run,
  output logic              busy,
  output logic [1:0]        halt_cause,
  output logic              done,
  output logic [ICNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_COUNT} state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_RUN_N = 2'b10;

  localparam logic [1:0] CAUSE_HOST = 2'd0;
  localparam logic [1:0] CAUSE_DONE = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_LOOP = 2'd3;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              first_q, first_d;
  logic [1:0]        cause_q, cause_d;
  logic              done_q, done_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;

  logic busy_w;
  logic bp_hit;
  logic loop_hit;

`ifdef OVERTURE_RUN_CTRL_LOOP_EN
  logic [7:0] pc_q, pc_d;
  logic       ran_last_q, ran_last_d;

  // A PC that did not move after a retired instruction is a jump-to-self.
  assign loop_hit = busy_w & ran_last_q & (cpu_pc == pc_q);

  always_comb begin
    pc_d       = cpu_pc;
    ran_last_d = cpu_run;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= 8'd0;
      ran_last_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ran_last_q <= ran_last_d;
    end
  end
`else
  assign loop_hit = 1'b0;
`endif

  assign busy_w = (state_q != ST_IDLE);
  // first_q masks the breakpoint for the first busy cycle so a resume from
  // the breakpoint PC executes that instruction.
  assign bp_hit  = bp_en & (cpu_pc == bp_addr) & ~first_q;
  assign cpu_run = busy_w & ~bp_hit & ~halt_req & ~loop_hit & ~reset;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = 1'b0;
    cause_d     = cause_q;
    done_d      = 1'b0;
    icnt_d      = icnt_q + {{(ICNT_W-1){1'b0}}, cpu_run};

    if (!busy_w) begin
      if (cmd_valid) begin
        if (halt_req) begin
          // Command consumed and discarded by a coincident host halt.
          cause_d = CAUSE_HOST;
          done_d  = 1'b1;
        end else begin
          case (cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              first_d = 1'b1;
            end
            OP_STEP: begin
              state_d     = ST_COUNT;
              remaining_d = {{(CNT_W-1){1'b0}}, 1'b1};
              first_d     = 1'b1;
            end
            OP_RUN_N: begin
              if (cmd_count == '0) begin
                cause_d = CAUSE_DONE;
                done_d  = 1'b1;
              end else begin
                state_d     = ST_COUNT;
                remaining_d = cmd_count;
                first_d     = 1'b1;
              end
            end
            default: ;  // reserved op: consumed, no effect
          endcase
        end
      end
    end else begin
      if (halt_req) begin
        state_d = ST_IDLE;
        cause_d = CAUSE_HOST;
        done_d  = 1'b1;
      end else if (bp_hit) begin
        state_d = ST_IDLE;
        cause_d = CAUSE_BP;
        done_d  = 1'b1;
      end else if (loop_hit) begin
        state_d = ST_IDLE;
        cause_d = CAUSE_LOOP;
        done_d  = 1'b1;
      end else if ((state_q == ST_COUNT) && cpu_run) begin
        remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      cause_q     <= CAUSE_HOST;
      done_q      <= 1'b0;
      icnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      cause_q     <= cause_d;
      done_q      <= done_d;
      icnt_q      <= icnt_d;
    end
  end

  assign cmd_ready   = ~busy_w;
  assign busy        = busy_w;
  assign halt_cause  = cause_q;
  assign done        = done_q;
  assign instr_count = icnt_q;

endmodule

// File: tb/tb_overture_run_ctrl.sv
module tb_overture_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        halt_req;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  cpu_pc;
  logic        cpu_run;
  logic        busy;
  logic [1:0]  halt_cause;
  logic        done;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic run_was;
  logic pc_incr;

  always #5 clk = ~clk;

  overture_run_ctrl #(.CNT_W(16), .ICNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc),
    .cpu_run(cpu_run), .busy(busy), .halt_cause(halt_cause), .done(done),
    .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample cpu_run before the edge, then model the CPU PC advance.
  task automatic cyc();
    #1;
    run_was = cpu_run;
    @(posedge clk);
    #1;
    if (run_was && pc_incr) cpu_pc = cpu_pc + 8'd1;
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] cnt);
    chk("cmd_ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cyc();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic watch(input int maxc, output int runs, output int dones);
    int n;
    n = 0; runs = 0; dones = 0;
    while (busy && n < maxc) begin
      cyc();
      if (run_was) runs++;
      if (done) dones++;
      n++;
    end
    chk("watch_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int r, d, rt, dt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
    halt_req = 1'b0; bp_en = 1'b0; bp_addr = 8'd0; cpu_pc = 8'd0; pc_incr = 1'b1;
    do_reset();
    chk("rst_cpu_run", {63'd0, cpu_run}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_halt_cause", {62'd0, halt_cause}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_instr_count", {32'd0, instr_count}, 64'd0);

    // run_n 5
    send(2'b10, 16'd5);
    watch(50, r, d);
    chk("runn5_runs", r, 5);
    chk("runn5_dones", d, 1);
    chk("runn5_cause", {62'd0, halt_cause}, 64'd1);
    chk("runn5_icnt", {32'd0, instr_count}, 64'd5);
    chk("runn5_ready", {63'd0, cmd_ready}, 64'd1);
    cyc();
    chk("runn5_done_single", {63'd0, done}, 64'd0);

    // three back-to-back steps
    rt = 0; dt = 0;
    for (int i = 0; i < 3; i++) begin
      send(2'b01, 16'd0);
      watch(10, r, d);
      rt += r; dt += d;
    end
    chk("step3_runs", rt, 3);
    chk("step3_dones", dt, 3);
    chk("step3_icnt", {32'd0, instr_count}, 64'd8);

    // breakpoint at 0x04, then resume with a step
    do_reset();
    cpu_pc = 8'd0; bp_en = 1'b1; bp_addr = 8'h04;
    send(2'b00, 16'd0);
    watch(50, r, d);
    chk("bp_runs", r, 4);
    chk("bp_dones", d, 1);
    chk("bp_pc", {56'd0, cpu_pc}, 64'h04);
    chk("bp_icnt", {32'd0, instr_count}, 64'd4);
    chk("bp_cause", {62'd0, halt_cause}, 64'd2);
    send(2'b01, 16'd0);
    watch(10, r, d);
    chk("bp_step_runs", r, 1);
    chk("bp_step_pc", {56'd0, cpu_pc}, 64'h05);
    chk("bp_step_cause", {62'd0, halt_cause}, 64'd1);
    bp_en = 1'b0;

    // host halt on cycle 10
    do_reset();
    cpu_pc = 8'd0;
    send(2'b00, 16'd0);
    for (int i = 0; i < 10; i++) cyc();
    halt_req = 1'b1;
    #1;
    chk("halt_cpu_run", {63'd0, cpu_run}, 64'd0);
    chk("halt_icnt_pre", {32'd0, instr_count}, 64'd10);
    cyc();
    halt_req = 1'b0;
    chk("halt_busy", {63'd0, busy}, 64'd0);
    chk("halt_done", {63'd0, done}, 64'd1);
    chk("halt_cause", {62'd0, halt_cause}, 64'd0);
    chk("halt_icnt", {32'd0, instr_count}, 64'd10);

    // reset mid-run
    send(2'b00, 16'd0);
    cyc(); cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("rstrun_cpu_run", {63'd0, cpu_run}, 64'd0);
    cyc();
    reset = 1'b0;
    chk("rstrun_done", {63'd0, done}, 64'd0);
    chk("rstrun_icnt", {32'd0, instr_count}, 64'd0);
    chk("rstrun_busy", {63'd0, busy}, 64'd0);
    cyc();
    chk("rstrun_done_after", {63'd0, done}, 64'd0);

    // halt_req idle, then coincident with a command
    halt_req = 1'b1;
    cyc();
    chk("idle_halt_done", {63'd0, done}, 64'd0);
    chk("idle_halt_busy", {63'd0, busy}, 64'd0);
    send(2'b00, 16'd0);
    halt_req = 1'b0;
    chk("coinc_busy", {63'd0, busy}, 64'd0);
    chk("coinc_done", {63'd0, done}, 64'd1);
    chk("coinc_cause", {62'd0, halt_cause}, 64'd0);

    // run_n 0, then reserved op
    send(2'b10, 16'd0);
    chk("runn0_busy", {63'd0, busy}, 64'd0);
    chk("runn0_done", {63'd0, done}, 64'd1);
    chk("runn0_cause", {62'd0, halt_cause}, 64'd1);
    chk("runn0_icnt", {32'd0, instr_count}, 64'd0);
    send(2'b11, 16'd9);
    chk("rsvd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rsvd_done", {63'd0, done}, 64'd0);
    chk("rsvd_cause", {62'd0, halt_cause}, 64'd1);
    chk("rsvd_icnt", {32'd0, instr_count}, 64'd0);

    // CPU stuck at 0x07
    pc_incr = 1'b0; cpu_pc = 8'h07;
    send(2'b00, 16'd0);
`ifdef OVERTURE_RUN_CTRL_LOOP_EN
    watch(20, r, d);
    chk("loop_runs", r, 1);
    chk("loop_dones", d, 1);
    chk("loop_cause", {62'd0, halt_cause}, 64'd3);
`else
    r = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (run_was) r++;
    end
    chk("noloop_runs", r, 20);
    chk("noloop_busy", {63'd0, busy}, 64'd1);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("noloop_cause", {62'd0, halt_cause}, 64'd0);
    chk("noloop_icnt", {32'd0, instr_count}, 64'd20);
`endif
    chk("loop_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
